// File: rtl/vga_watermark_compositor.sv
// VGA scan-out with per-frame source selection, keyed watermark alpha blend
// and a flat status colour while the processor is busy.
module vga_watermark_compositor #(
    parameter int          CLK_DIV    = 4,
    parameter int          NUM_SRC    = 3,
    parameter int          SEL_W      = 2,
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter logic        SYNC_POL   = 1'b0,
    parameter logic [11:0] KEY_COLOR  = 12'h000,
    parameter logic [11:0] WAIT_COLOR = 12'h888
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [12*NUM_SRC-1:0]  src_pix,
    input  logic [SEL_W-1:0]       src_sel,
    input  logic [11:0]            water_pix,
    input  logic                   water_en,
    input  logic [1:0]             alpha_sh,
    input  logic                   waiting,
    input  logic                   done,
    output logic [9:0]             pix_x,
    output logic [9:0]             pix_y,
    output logic                   pix_valid,
    output logic                   frame_start,
    output logic [11:0]            COLOR_OUT,
    output logic                   HS,
    output logic                   VS
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Per component: c - (c>>s) + (w>>s); never exceeds 15, so no clamp.
    function automatic logic [11:0] blend(input logic [11:0] c, input logic [11:0] w,
                                          input logic [1:0] s);
        logic [11:0] res;
        logic [3:0]  cc;
        logic [3:0]  ww;
        res = '0;
        for (int k = 0; k < 3; k++) begin
            cc = c[4*k +: 4];
            ww = w[4*k +: 4];
            res[4*k +: 4] = cc - (cc >> s) + (ww >> s);
        end
        return res;
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             tick;
    logic             frame_tick;

    logic [9:0]       pix_x_q, pix_y_q;
    logic             vld_p0_q, hs_p0_q, vs_p0_q;
    logic             frame_start_q;

    logic [11:0]      pix_p1_q, water_p1_q;
    logic             vld_p1_q, hs_p1_q, vs_p1_q, wait_p1_q;

    logic [11:0]      color_q, color_d;
    logic             hs_q, vs_q;

    logic [SEL_W-1:0] sel_q, sel_d;
    logic             en_q;
    logic [1:0]       sh_q;
    logic             done_seen_q;
    logic [11:0]      src_mux;

    assign tick       = (div_q == DIV_LAST);
    assign frame_tick = tick && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    always_comb begin
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_comb begin
        sel_d = (32'(src_sel) < NUM_SRC) ? src_sel : '0;
    end

    always_comb begin
        src_mux = src_pix[11:0];
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_q == SEL_W'(k)) src_mux = src_pix[12*k +: 12];
        end
    end

    always_comb begin
        color_d = 12'h000;
        if (vld_p1_q) begin
            if (wait_p1_q)
                color_d = WAIT_COLOR;
            else if (!done_seen_q)
                color_d = 12'h000;
            else if (en_q && (water_p1_q != KEY_COLOR))
                color_d = blend(pix_p1_q, water_p1_q, sh_q);
            else
                color_d = pix_p1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            vld_p0_q      <= 1'b0;
            hs_p0_q       <= 1'b0;
            vs_p0_q       <= 1'b0;
            frame_start_q <= 1'b0;
            pix_p1_q      <= '0;
            water_p1_q    <= '0;
            vld_p1_q      <= 1'b0;
            hs_p1_q       <= 1'b0;
            vs_p1_q       <= 1'b0;
            wait_p1_q     <= 1'b0;
            color_q       <= '0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            sel_q         <= '0;
            en_q          <= 1'b0;
            sh_q          <= '0;
            done_seen_q   <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_tick;
            if (done) done_seen_q <= 1'b1;
            // Frame controls only change at the frame boundary, and only once done was seen.
            if (frame_tick && done_seen_q) begin
                sel_q <= sel_d;
                en_q  <= water_en;
                sh_q  <= alpha_sh;
            end
            if (tick) begin
                // Stage 0: address and raw timing flags
                pix_x_q  <= h_cnt_q;
                pix_y_q  <= v_cnt_q;
                vld_p0_q <= (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
                hs_p0_q  <= (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END);
                vs_p0_q  <= (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END);
                // Stage 1: source data returned for the stage-0 address
                pix_p1_q   <= src_mux;
                water_p1_q <= water_pix;
                vld_p1_q   <= vld_p0_q;
                hs_p1_q    <= hs_p0_q;
                vs_p1_q    <= vs_p0_q;
                wait_p1_q  <= waiting;
                // Stage 2: pin registers
                color_q <= color_d;
                hs_q    <= hs_p1_q ? SYNC_POL : ~SYNC_POL;
                vs_q    <= vs_p1_q ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_valid   = vld_p0_q;
    assign frame_start = frame_start_q;
    assign COLOR_OUT   = color_q;
    assign HS          = hs_q;
    assign VS          = vs_q;

endmodule

// File: tb/tb_vga_watermark_compositor.sv
// Directed bench for vga_watermark_compositor on a 14x7-tick raster, CLK_DIV=2.
module tb_vga_watermark_compositor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [35:0] src_pix;
    logic [1:0]  src_sel;
    logic [11:0] water_pix;
    logic        water_en;
    logic [1:0]  alpha_sh;
    logic        waiting;
    logic        done;
    logic [9:0]  pix_x, pix_y;
    logic        pix_valid, frame_start;
    logic [11:0] COLOR_OUT;
    logic        HS, VS;

    int checks   = 0;
    int failures = 0;

    vga_watermark_compositor #(
        .CLK_DIV(2), .NUM_SRC(3), .SEL_W(2),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .KEY_COLOR(12'h000), .WAIT_COLOR(12'h888)
    ) dut (
        .clk(clk), .rst_n(rst_n), .src_pix(src_pix), .src_sel(src_sel),
        .water_pix(water_pix), .water_en(water_en), .alpha_sh(alpha_sh),
        .waiting(waiting), .done(done), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .frame_start(frame_start), .COLOR_OUT(COLOR_OUT),
        .HS(HS), .VS(VS)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Returns the number of negedges until frame_start is seen (bounded).
    task automatic wait_fs(output int clks);
        clks = 0;
        do begin
            @(negedge clk);
            clks++;
        end while (!frame_start && clks < 400);
        check_eq("frame_start_seen", {31'd0, frame_start}, 32'd1);
    endtask

    // Lands on the negedge where COLOR_OUT shows pixel n of the next frame.
    task automatic goto_pixel(input int n);
        int c;
        wait_fs(c);
        repeat (2 * (n + 2)) @(negedge clk);
    endtask

    task automatic measure_sync(input bit use_vs, output int low_clks, output int period_clks);
        logic prev, cur;
        bit   fell, seen_high;
        int   n;
        n = 0;
        fell = 1'b0;
        prev = use_vs ? VS : HS;
        while (!fell && n < 600) begin
            @(negedge clk);
            n++;
            cur  = use_vs ? VS : HS;
            fell = prev && !cur;
            prev = cur;
        end
        low_clks    = 1;
        period_clks = 0;
        seen_high   = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            period_clks++;
            cur = use_vs ? VS : HS;
            if (!cur && seen_high) break;
            if (cur) seen_high = 1'b1;
            else if (!seen_high) low_clks++;
        end
    endtask

    initial begin
        int n, lo, per;
        rst_n     = 1'b0;
        src_pix   = {12'h3C7, 12'hA5C, 12'h1E2};
        src_sel   = 2'd1;
        water_pix = 12'h000;
        water_en  = 1'b0;
        alpha_sh  = 2'd0;
        waiting   = 1'b0;
        done      = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_pix_x", 32'(pix_x), 32'd0);
        check_eq("rst_pix_valid", 32'(pix_valid), 32'd0);
        check_eq("rst_frame_start", 32'(frame_start), 32'd0);
        check_eq("rst_color", 32'(COLOR_OUT), 32'h000);
        check_eq("rst_hs", 32'(HS), 32'd1);
        check_eq("rst_vs", 32'(VS), 32'd1);

        rst_n = 1'b1;
        wait_fs(n);
        check_eq("fs_first_latency", n, 32'd2);
        check_eq("fs_first_xy", {pix_x, pix_y}, 32'd0);
        check_eq("fs_first_valid", 32'(pix_valid), 32'd1);
        wait_fs(n);
        check_eq("fs_period", n, 32'd196);

        measure_sync(1'b0, lo, per);
        check_eq("hs_low_clks", lo, 32'd4);
        check_eq("hs_period_clks", per, 32'd28);
        measure_sync(1'b1, lo, per);
        check_eq("vs_low_clks", lo, 32'd28);
        check_eq("vs_period_clks", per, 32'd196);

        goto_pixel(0);
        check_eq("pre_done_black", 32'(COLOR_OUT), 32'h000);

        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        goto_pixel(0);
        check_eq("src1_px0", 32'(COLOR_OUT), 32'hA5C);
        repeat (6) @(negedge clk);
        check_eq("src1_px3", 32'(COLOR_OUT), 32'hA5C);
        repeat (12) @(negedge clk);
        check_eq("hblank_px9_color", 32'(COLOR_OUT), 32'h000);
        check_eq("hblank_px9_hs", 32'(HS), 32'd1);
        repeat (2) @(negedge clk);
        check_eq("hsync_px10_color", 32'(COLOR_OUT), 32'h000);
        check_eq("hsync_px10_hs", 32'(HS), 32'd0);
        repeat (124) @(negedge clk);
        check_eq("vsync_px72_color", 32'(COLOR_OUT), 32'h000);
        check_eq("vsync_px72_vs", 32'(VS), 32'd0);

        src_pix   = {12'h3C7, 12'hF00, 12'h1E2};
        water_en  = 1'b1;
        alpha_sh  = 2'd1;
        water_pix = 12'h0F0;
        goto_pixel(0);
        check_eq("blend_s1", 32'(COLOR_OUT), 32'h870);
        water_pix = 12'h000;
        repeat (4) @(negedge clk);
        check_eq("blend_keyed", 32'(COLOR_OUT), 32'hF00);
        water_pix = 12'h0F0;
        alpha_sh  = 2'd0;
        goto_pixel(0);
        check_eq("blend_s0_replace", 32'(COLOR_OUT), 32'h0F0);
        alpha_sh = 2'd2;
        goto_pixel(0);
        check_eq("blend_s2", 32'(COLOR_OUT), 32'hC30);
        alpha_sh  = 2'd3;
        src_pix   = {12'h3C7, 12'hA5C, 12'h1E2};
        water_pix = 12'h4F8;
        goto_pixel(0);
        check_eq("blend_s3", 32'(COLOR_OUT), 32'h96C);
        water_en = 1'b0;

        goto_pixel(0);
        check_eq("sel1_frame", 32'(COLOR_OUT), 32'hA5C);
        src_sel = 2'd2;
        repeat (56) @(negedge clk);
        check_eq("sel_midframe_hold", 32'(COLOR_OUT), 32'hA5C);
        goto_pixel(0);
        check_eq("sel2_next_frame", 32'(COLOR_OUT), 32'h3C7);
        src_sel = 2'd3;
        goto_pixel(0);
        check_eq("sel3_to_src0", 32'(COLOR_OUT), 32'h1E2);
        src_sel = 2'd1;

        goto_pixel(14);
        check_eq("wait_before", 32'(COLOR_OUT), 32'hA5C);
        waiting = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("wait_1tick", 32'(COLOR_OUT), 32'hA5C);
        repeat (2) @(negedge clk);
        check_eq("wait_2ticks", 32'(COLOR_OUT), 32'h888);
        repeat (16) @(negedge clk);
        check_eq("wait_blank", 32'(COLOR_OUT), 32'h000);
        waiting = 1'b0;

        goto_pixel(16);
        check_eq("prereset_color", 32'(COLOR_OUT), 32'hA5C);
        rst_n = 1'b0;
        #1;
        check_eq("midreset_color", 32'(COLOR_OUT), 32'h000);
        check_eq("midreset_xy", {pix_x, pix_y}, 32'd0);
        check_eq("midreset_valid", 32'(pix_valid), 32'd0);
        check_eq("midreset_hs", 32'(HS), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs(n);
        check_eq("rerelease_fs_latency", n, 32'd2);
        check_eq("rerelease_xy", {pix_x, pix_y}, 32'd0);
        goto_pixel(0);
        check_eq("done_seen_cleared", 32'(COLOR_OUT), 32'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
